// File: rtl/spi_one_ch_pkg.sv
// Shared types and default constants for the single-channel SPI ADC reader.
package spi_one_ch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        DONE
    } state_t;

    localparam int              HALF_DIV_DEFAULT   = 50;
    localparam int              FRAME_BITS_DEFAULT = 16;
    localparam int              DATA_BITS_DEFAULT  = 12;
    localparam logic [15:0]     CTRL_WORD_DEFAULT  = 16'h0000;

    // Counter width helper that never returns zero, so a divide-by-one
    // configuration still yields a legal one-bit counter.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_one_ch_tick.sv
// Half-period timer: one-clock tick every HALF_DIV clocks while enabled,
// held at zero while disabled so each enabled run starts from a full period.
module spi_one_ch_tick
    import spi_one_ch_pkg::*;
#(
    parameter int HALF_DIV = HALF_DIV_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    output logic tick
);

    localparam int            CW   = cnt_width(HALF_DIV);
    localparam logic [CW-1:0] LAST = CW'(HALF_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    // Count while enabled, wrap on tick, clear when disabled.
    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (!en || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spi_one_ch.sv
// Single-channel SPI master: one ADC128S022-style 16-clock frame per start
// button edge, CPOL=1, MOSI launched on falling dclk, MISO sampled on rising.
module spi_one_ch
    import spi_one_ch_pkg::*;
#(
    parameter int                    HALF_DIV   = HALF_DIV_DEFAULT,
    parameter int                    FRAME_BITS = FRAME_BITS_DEFAULT,
    parameter int                    DATA_BITS  = DATA_BITS_DEFAULT,
    parameter logic [FRAME_BITS-1:0] CTRL_WORD  = FRAME_BITS'(CTRL_WORD_DEFAULT)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 button_i,
    input  logic                 miso_i,
    output logic                 mosi_o,
    output logic [DATA_BITS-1:0] dout_o,
    output logic                 dclk_o,
    output logic                 cs_o,
    output logic                 eoc_o
);

    localparam int BW = cnt_width(FRAME_BITS + 1);

    state_t                state, state_n;
    logic [FRAME_BITS-1:0] tx, tx_n;
    logic [FRAME_BITS-1:0] rx, rx_n;
    logic [BW-1:0]         bit_cnt, bit_cnt_n;
    logic [DATA_BITS-1:0]  dout_n;
    logic                  btn_r, btn_prev;
    logic                  start;
    logic                  tick;
    logic                  active, active_n;

    assign start    = btn_r && !btn_prev;
    assign active   = (state == SETUP) || (state == LOW) || (state == HIGH);
    assign active_n = (state_n == SETUP) || (state_n == LOW) || (state_n == HIGH);

    spi_one_ch_tick #(
        .HALF_DIV (HALF_DIV)
    ) u_tick (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (active),
        .tick  (tick)
    );

    // Register the button and keep its previous registered value for edge detect.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            btn_r    <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_r    <= button_i;
            btn_prev <= btn_r;
        end
    end

    // Next-state and datapath updates; all transitions happen on a half-period tick.
    // NOTE: every output of this block gets a default first, so no latch is inferred.
    always_comb begin
        state_n   = state;
        tx_n      = tx;
        rx_n      = rx;
        bit_cnt_n = bit_cnt;
        dout_n    = dout_o;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n   = SETUP;
                    tx_n      = CTRL_WORD;
                    bit_cnt_n = '0;
                end
            end
            SETUP: begin
                if (tick) state_n = LOW;
            end
            LOW: begin
                // Leaving LOW is the dclk rising edge: capture MISO.
                if (tick) begin
                    state_n   = HIGH;
                    rx_n      = {rx[FRAME_BITS-2:0], miso_i};
                    bit_cnt_n = bit_cnt + BW'(1);
                end
            end
            HIGH: begin
                if (tick) begin
                    if (bit_cnt == BW'(FRAME_BITS)) begin
                        state_n = DONE;
                        dout_n  = rx[DATA_BITS-1:0];
                    end else begin
                        // Falling edge after a sampled bit: launch the next control bit.
                        state_n = LOW;
                        tx_n    = {tx[FRAME_BITS-2:0], 1'b0};
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, shift registers and glitch-free registered pin outputs.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            tx      <= '0;
            rx      <= '0;
            bit_cnt <= '0;
            dout_o  <= '0;
            cs_o    <= 1'b1;
            dclk_o  <= 1'b1;
            mosi_o  <= 1'b0;
            eoc_o   <= 1'b0;
        end else begin
            state   <= state_n;
            tx      <= tx_n;
            rx      <= rx_n;
            bit_cnt <= bit_cnt_n;
            dout_o  <= dout_n;
            cs_o    <= !active_n;
            dclk_o  <= (state_n != LOW);
            mosi_o  <= active_n ? tx_n[FRAME_BITS-1] : 1'b0;
            eoc_o   <= (state_n == DONE);
        end
    end

endmodule

// File: tb/tb_spi_one_ch.sv
// Self-checking bench for spi_one_ch: table-driven frames with an ADC model,
// plus hand-written busy-ignore and mid-frame reset sequences.
module tb_spi_one_ch;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        button_i;
    logic        miso_i = 1'b1;
    logic        mosi_o;
    logic [11:0] dout_o;
    logic        dclk_o;
    logic        cs_o;
    logic        eoc_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    spi_one_ch dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .button_i (button_i),
        .miso_i   (miso_i),
        .mosi_o   (mosi_o),
        .dout_o   (dout_o),
        .dclk_o   (dclk_o),
        .cs_o     (cs_o),
        .eoc_o    (eoc_o)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // ADC model: shifts adc_pat out MSB first, changing MISO on each dclk fall.
    logic [15:0] adc_pat = 16'hFFFF;
    int          adc_idx = 0;
    always @(negedge dclk_o or negedge cs_o) begin
        if (dclk_o) begin
            adc_idx = 0;
        end else if (!cs_o && adc_idx < 16) begin
            miso_i  = adc_pat[15 - adc_idx];
            adc_idx = adc_idx + 1;
        end
    end

    // Monitor sampled 1 ns after each rising edge.
    int          cyc = 0, falls = 0, eoc_cnt = 0, mosi_hi = 0, frame_falls = 0;
    int          cs_fall_cyc = 0, first_fall = 0, last_fall = 0, eoc_cyc = 0;
    logic        dclk_prev = 1'b1, cs_prev = 1'b1;
    logic [11:0] dout_at_eoc = '0;
    always @(posedge clk) begin
        #1;
        cyc = cyc + 1;
        if (cs_prev && !cs_o) begin
            cs_fall_cyc = cyc;
            frame_falls = 0;
        end
        if (dclk_prev && !dclk_o) begin
            if (frame_falls == 0) first_fall = cyc;
            last_fall   = cyc;
            frame_falls = frame_falls + 1;
            falls       = falls + 1;
        end
        if (eoc_o) begin
            eoc_cnt     = eoc_cnt + 1;
            eoc_cyc     = cyc;
            dout_at_eoc = dout_o;
        end
        if (!cs_o && mosi_o) mosi_hi = mosi_hi + 1;
        dclk_prev = dclk_o;
        cs_prev   = cs_o;
    end

    task automatic press();
        @(negedge clk) button_i = 1'b1;
        @(negedge clk) button_i = 1'b0;
    endtask

    task automatic run_frame(input logic [15:0] pat, input logic [11:0] exp,
                             input bit busy, input int id);
        int e0, f0, m0, n;
        e0 = eoc_cnt;
        f0 = falls;
        m0 = mosi_hi;
        n  = 0;
        adc_pat = pat;
        press();
        if (busy) begin
            repeat (500) @(negedge clk);
            press();
        end
        while (eoc_cnt == e0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("v%0d_eoc_seen", id), 32'(eoc_cnt != e0), 32'd1);
        repeat (200) @(negedge clk);
        check($sformatf("v%0d_eoc_count", id), 32'(eoc_cnt - e0), 32'd1);
        check($sformatf("v%0d_dclk_falls", id), 32'(falls - f0), 32'd16);
        check($sformatf("v%0d_cs_to_eoc", id), 32'(eoc_cyc - cs_fall_cyc), 32'd1650);
        check($sformatf("v%0d_cs_setup", id), 32'(first_fall - cs_fall_cyc), 32'd50);
        check($sformatf("v%0d_dclk_span", id), 32'(last_fall - first_fall), 32'd1500);
        check($sformatf("v%0d_dout_at_eoc", id), 32'(dout_at_eoc), 32'(exp));
        check($sformatf("v%0d_dout_hold", id), 32'(dout_o), 32'(exp));
        check($sformatf("v%0d_mosi_zero", id), 32'(mosi_hi - m0), 32'd0);
        check($sformatf("v%0d_cs_idle", id), 32'(cs_o), 32'd1);
        check($sformatf("v%0d_dclk_idle", id), 32'(dclk_o), 32'd1);
    endtask

    typedef struct {
        logic [15:0] pat;
        logic [11:0] exp;
        bit          busy;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int e0, f0, n;

        vecs[0] = '{pat: 16'hFFFF, exp: 12'hFFF, busy: 1'b0};
        vecs[1] = '{pat: 16'hFFFF, exp: 12'hFFF, busy: 1'b0};
        vecs[2] = '{pat: 16'h0A5C, exp: 12'hA5C, busy: 1'b0};
        vecs[3] = '{pat: 16'h0000, exp: 12'h000, busy: 1'b0};
        vecs[4] = '{pat: 16'hF123, exp: 12'h123, busy: 1'b1};
        vecs[5] = '{pat: 16'h0800, exp: 12'h800, busy: 1'b0};

        rst_i    = 1'b0;
        button_i = 1'b0;
        @(negedge clk);
        check("rst_cs", 32'(cs_o), 32'd1);
        check("rst_dclk", 32'(dclk_o), 32'd1);
        check("rst_mosi", 32'(mosi_o), 32'd0);
        check("rst_dout", 32'(dout_o), 32'h000);
        check("rst_eoc", 32'(eoc_o), 32'd0);
        rst_i = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(vecs[i].pat, vecs[i].exp, vecs[i].busy, i);
        end

        // Reset in the middle of a frame: outputs return at once, no eoc.
        e0 = eoc_cnt;
        f0 = falls;
        n  = 0;
        adc_pat = 16'h0FFF;
        press();
        while (falls - f0 < 8 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("mid_reached_bit8", 32'(falls - f0), 32'd8);
        rst_i = 1'b0;
        #1;
        check("mid_rst_cs", 32'(cs_o), 32'd1);
        check("mid_rst_dclk", 32'(dclk_o), 32'd1);
        check("mid_rst_dout", 32'(dout_o), 32'h000);
        check("mid_rst_eoc", 32'(eoc_o), 32'd0);
        check("mid_rst_mosi", 32'(mosi_o), 32'd0);
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        repeat (2000) @(negedge clk);
        check("mid_no_eoc", 32'(eoc_cnt - e0), 32'd0);
        check("mid_dout_kept_zero", 32'(dout_o), 32'h000);
        check("mid_cs_idle", 32'(cs_o), 32'd1);

        run_frame(16'h0123, 12'h123, 1'b0, 6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spi_one_ch.md
Name: spi_one_ch

Overview:
- Single-channel SPI master that reads one conversion from an external 12-bit ADC (ADC128S022-style, 16-clock frame) each time a start button pulse arrives.
- Shifts a fixed control word out on MOSI and captures the 12-bit result from MISO.
- Presents the result on a parallel bus and flags completion with a one-cycle end-of-conversion pulse.
- Sits between board-level pushbutton/ADC pins and downstream logic that consumes dout_o.

Parameters:
- HALF_DIV, 50: system clocks per dclk half-period. At 100 MHz this gives a 1 MHz dclk.
- FRAME_BITS, 16: dclk cycles per frame.
- DATA_BITS, 12: result width, taken from the last 12 bits received in the frame.
- CTRL_WORD, 16'h0000: word shifted out on MOSI, MSB first. Bits 13:11 select ADC channel 0.

Ports:
- clk_i  in  1  system clock, 100 MHz, rising edge.
- rst_i  in  1  asynchronous active-low reset.
- button_i  in  1  start request; rising edge triggers one frame; may be a single-clock pulse.
- miso_i  in  1  serial data from the ADC.
- mosi_o  out  1  serial data to the ADC.
- dout_o  out  12  last captured conversion result.
- dclk_o  out  1  SPI clock, CPOL=1 (idles high).
- cs_o  out  1  active-low chip select.
- eoc_o  out  1  one-cycle pulse when dout_o is updated.

Behaviour:
- Reset (rst_i=0, asynchronous): state IDLE, cs_o=1, dclk_o=1, mosi_o=0, dout_o=0, eoc_o=0, all counters 0.
- Start detection:
  - button_i is registered once, and a rising edge is detected against its previous registered value.
  - A 1-clock-wide high pulse is sufficient to trigger a frame.
  - Edges arriving while not in IDLE are ignored; they are not queued.
- State machine: IDLE -> SETUP -> LOW -> HIGH -> (LOW ... ) -> DONE -> IDLE.
- IDLE:
  - Outputs hold at their idle values.
  - On a start edge: cs_o goes to 0 on the next clock, the shift register loads CTRL_WORD, and the bit counter clears.
  - mosi_o presents CTRL_WORD[15].
- SETUP: cs_o=0, dclk_o=1 for HALF_DIV clocks (CS setup time). Then go to LOW.
- LOW:
  - dclk_o=0 for HALF_DIV clocks.
  - On entry (the dclk falling edge), mosi_o is updated to the next control bit. Bit 15 is already valid from SETUP.
  - Then go to HIGH.
- HIGH:
  - dclk_o=1 for HALF_DIV clocks.
  - On entry (the dclk rising edge), miso_i is sampled into the receive shift register, MSB first, and the bit counter increments.
  - If the counter reaches FRAME_BITS, go to DONE at the end of the half-period; otherwise go to LOW.
- DONE (single clock):
  - cs_o=1, dclk_o=1, mosi_o=0.
  - dout_o loads rx[11:0], i.e. the last 12 bits received.
  - eoc_o=1 for exactly this cycle. Then go to IDLE.
- Frame length: 1 + HALF_DIV + FRAME_BITS*2*HALF_DIV + 1 clocks from the start edge, which is 1652 clocks (16.52 us) at the default parameters.
- dout_o holds its value between frames. It changes only in DONE or on reset.
- Reset mid-frame: immediate return to the reset values; a partial frame never updates dout_o and never pulses eoc_o.
- Timing: a single half-period counter of width clog2(HALF_DIV) is used. No combinational path from miso_i to any output.

Decomposition:
- Shared package spi_one_ch_pkg:
  - state enum {IDLE, SETUP, LOW, HIGH, DONE};
  - default HALF_DIV, FRAME_BITS, DATA_BITS and CTRL_WORD constants.
- One sub-module, spi_one_ch_tick: the half-period counter, which emits a one-clock tick every HALF_DIV clocks while enabled and clears when disabled.
- The FSM and the shift registers live in the top level.

Test Plan:
- Reset: hold rst_i=0 for 1 clock, with miso_i=1 -> cs_o=1, dclk_o=1, mosi_o=0, dout_o=12'h000, eoc_o=0.
- Single read of all ones: miso_i=1, 1-clock button_i pulse at 30 ns -> cs_o low, exactly 16 dclk falling edges with 1 us period, then dout_o=12'hFFF and one eoc_o pulse roughly 16.5 us after the start edge; cs_o high afterwards.
- Second read after 24 us: repeat the pulse -> a second identical frame, dout_o stays 12'hFFF, exactly one further eoc_o pulse.
- Data pattern: a bench ADC model drives 4 zero bits then 12'hA5C on dclk falling edges -> dout_o=12'hA5C; mosi_o stays 0 for the whole frame (CTRL_WORD=0).
- Busy ignore: a second button_i pulse 5 us into a frame -> no restart, exactly one eoc_o, and a frame length of 1652 clocks.
- Reset mid-frame: assert rst_i=0 during bit 8 -> cs_o=1 immediately, dout_o=0, no eoc_o; a subsequent button pulse runs a clean frame.
